// File: rtl/vx_mem_sched_pkg.sv
// vx_mem_sched_pkg: shared types and width helpers for the memory request scheduler.
package vx_mem_sched_pkg;
  typedef enum logic [1:0] {RUN, DRAIN, DONE} sched_state_e;
  function automatic int sel_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int cnt_w(input int m);
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/vx_mem_sched_credit.sv
// vx_mem_sched_credit: per-requester outstanding-read counter, saturating at 0 and MAX_PENDING.
module vx_mem_sched_credit #(
  parameter int MAX_PENDING = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             full,
  output logic             empty
);
  assign full = cnt >= CNT_W'(MAX_PENDING);
  assign empty = cnt == '0;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (inc && !dec && !full) cnt <= cnt + CNT_W'(1);
    else if (dec && !inc && !empty) cnt <= cnt - CNT_W'(1);
endmodule

// File: rtl/vx_mem_req_sched.sv
// vx_mem_req_sched: credit-throttled round-robin arbiter sharing one memory port,
// tagging requests with the requester index and routing responses back by that index.
module vx_mem_req_sched import vx_mem_sched_pkg::*; #(
  parameter int NUM_REQS = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH = 8,
  parameter int MAX_PENDING = 8,
  localparam int SEL_BITS = sel_bits(NUM_REQS),
  localparam int CNT_W = cnt_w(MAX_PENDING)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQS-1:0]            req_valid_in,
  input  logic [NUM_REQS-1:0]            req_rw_in,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0] req_addr_in,
  input  logic [NUM_REQS*DATA_WIDTH-1:0] req_data_in,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]  req_tag_in,
  output logic [NUM_REQS-1:0]            req_ready_in,
  output logic                           mem_req_valid,
  output logic                           mem_req_rw,
  output logic [ADDR_WIDTH-1:0]          mem_req_addr,
  output logic [DATA_WIDTH-1:0]          mem_req_data,
  output logic [TAG_WIDTH+SEL_BITS-1:0]  mem_req_tag,
  input  logic                           mem_req_ready,
  input  logic                           mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]          mem_rsp_data,
  input  logic [TAG_WIDTH+SEL_BITS-1:0]  mem_rsp_tag,
  output logic                           mem_rsp_ready,
  output logic [NUM_REQS-1:0]            rsp_valid_out,
  output logic [DATA_WIDTH-1:0]          rsp_data_out,
  output logic [TAG_WIDTH-1:0]           rsp_tag_out,
  input  logic [NUM_REQS-1:0]            rsp_ready_out,
  input  logic                           flush_req,
  output logic                           flush_done,
  output logic                           err_out
);
  sched_state_e state;
  logic [SEL_BITS-1:0] ptr, grant, sel;
  logic found, gnt, can_load, rsp_hs, drained;
  logic [NUM_REQS-1:0] elig, full, empty, inc, dec;
  logic [CNT_W-1:0] cnt [NUM_REQS];
  assign sel = mem_rsp_tag[SEL_BITS-1:0];
  assign can_load = !mem_req_valid || mem_req_ready;
  assign elig = (state == RUN) ? req_valid_in & (req_rw_in | ~full) : '0;
  always_comb begin
    int j;
    found = 1'b0;
    grant = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      j = int'(ptr) + k;
      j = (j >= NUM_REQS) ? j - NUM_REQS : j;
      if (!found && elig[j]) begin
        found = 1'b1;
        grant = SEL_BITS'(j);
      end
    end
  end
  assign gnt = found && can_load && reset_n;
  assign req_ready_in = gnt ? NUM_REQS'(1) << grant : '0;
  // Response path is purely combinational; forced quiet while reset is held.
  assign mem_rsp_ready = reset_n && rsp_ready_out[sel];
  assign rsp_hs = mem_rsp_valid && mem_rsp_ready;
  assign rsp_valid_out = (reset_n && mem_rsp_valid) ? NUM_REQS'(1) << sel : '0;
  assign rsp_data_out = reset_n ? mem_rsp_data : '0;
  assign rsp_tag_out = reset_n ? mem_rsp_tag[TAG_WIDTH+SEL_BITS-1:SEL_BITS] : '0;
  assign drained = !mem_req_valid && (&empty);
  for (genvar i = 0; i < NUM_REQS; i++) begin : g_cr
    assign inc[i] = gnt && (grant == SEL_BITS'(i)) && !req_rw_in[i];
    assign dec[i] = rsp_hs && (sel == SEL_BITS'(i));
    vx_mem_sched_credit #(.MAX_PENDING(MAX_PENDING), .CNT_W(CNT_W)) u_cr (
      .clk(clk), .reset_n(reset_n), .inc(inc[i]), .dec(dec[i]),
      .cnt(cnt[i]), .full(full[i]), .empty(empty[i])
    );
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      mem_req_valid <= 1'b0;
      mem_req_rw <= 1'b0;
      mem_req_addr <= '0;
      mem_req_data <= '0;
      mem_req_tag <= '0;
      ptr <= '0;
      state <= RUN;
      flush_done <= 1'b0;
      err_out <= 1'b0;
    end else begin
      if (can_load) mem_req_valid <= gnt;
      if (gnt) begin
        mem_req_rw <= req_rw_in[grant];
        mem_req_addr <= req_addr_in[grant*ADDR_WIDTH +: ADDR_WIDTH];
        mem_req_data <= req_data_in[grant*DATA_WIDTH +: DATA_WIDTH];
        mem_req_tag <= {req_tag_in[grant*TAG_WIDTH +: TAG_WIDTH], grant};
        ptr <= (int'(grant) == NUM_REQS - 1) ? '0 : grant + SEL_BITS'(1);
      end
      err_out <= err_out || (rsp_hs && cnt[sel] == '0);
      flush_done <= (state == DRAIN) && drained;
      state <= (state == RUN && flush_req) ? DRAIN :
               (state == DRAIN && drained) ? DONE :
               (state == DONE) ? RUN : state;
    end
endmodule

// File: tb/tb_vx_mem_req_sched.sv
// tb_vx_mem_req_sched: directed and table-driven checks of grant order, credits,
// backpressure, flush handshake, error flag and response routing.
module tb_vx_mem_req_sched;
  localparam int N = 4;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int TW = 8;
  logic clk = 1'b0;
  logic reset_n;
  logic [N-1:0] req_valid_in, req_rw_in, req_ready_in;
  logic [N*AW-1:0] req_addr_in;
  logic [N*DW-1:0] req_data_in;
  logic [N*TW-1:0] req_tag_in;
  logic mem_req_valid, mem_req_rw, mem_req_ready;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_data;
  logic [TW+1:0] mem_req_tag;
  logic mem_rsp_valid, mem_rsp_ready;
  logic [DW-1:0] mem_rsp_data, rsp_data_out;
  logic [TW+1:0] mem_rsp_tag;
  logic [N-1:0] rsp_valid_out, rsp_ready_out;
  logic [TW-1:0] rsp_tag_out;
  logic flush_req, flush_done, err_out;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vx_mem_req_sched #(.NUM_REQS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .MAX_PENDING(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid_in(req_valid_in), .req_rw_in(req_rw_in), .req_addr_in(req_addr_in),
    .req_data_in(req_data_in), .req_tag_in(req_tag_in), .req_ready_in(req_ready_in),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_tag(mem_rsp_tag),
    .mem_rsp_ready(mem_rsp_ready), .rsp_valid_out(rsp_valid_out), .rsp_data_out(rsp_data_out),
    .rsp_tag_out(rsp_tag_out), .rsp_ready_out(rsp_ready_out),
    .flush_req(flush_req), .flush_done(flush_done), .err_out(err_out)
  );

  typedef struct {
    logic v;
    logic [TW+1:0] tag;
    logic [N-1:0] rdy;
    logic [DW-1:0] data;
    logic [N-1:0] e_valid;
    logic e_mrdy;
    logic [TW-1:0] e_tag;
  } rvec_t;
  rvec_t tbl[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_mem_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_ready", 64'(req_ready_in), 64'd0);
    chk("rst_err", 64'(err_out), 64'd0);
    chk("rst_flush_done", 64'(flush_done), 64'd0);
    tick();
    tick();
    reset_n = 1'b1;
    #1;
  endtask

  initial begin
    tbl[0] = '{1'b1, {8'h5A, 2'd0}, 4'hF, 64'h1111, 4'b0001, 1'b1, 8'h5A};
    tbl[1] = '{1'b1, {8'hC3, 2'd3}, 4'hF, 64'h2222, 4'b1000, 1'b1, 8'hC3};
    tbl[2] = '{1'b1, {8'h01, 2'd2}, 4'b1011, 64'h3333, 4'b0100, 1'b0, 8'h01};
    tbl[3] = '{1'b0, {8'h77, 2'd1}, 4'hF, 64'h4444, 4'b0000, 1'b1, 8'h77};
    tbl[4] = '{1'b1, {8'hFF, 2'd1}, 4'b0010, 64'h5555, 4'b0010, 1'b1, 8'hFF};
    tbl[5] = '{1'b1, {8'h00, 2'd3}, 4'b0111, 64'h6666, 4'b1000, 1'b0, 8'h00};
    reset_n = 1'b0;
    req_valid_in = 4'hF;
    req_rw_in = '0;
    req_addr_in = '0;
    req_data_in = '0;
    req_tag_in = '0;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rsp_data = '0;
    mem_rsp_tag = '0;
    rsp_ready_out = 4'hF;
    flush_req = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_addr_in[i*AW +: AW] = 32'h100 + 32'(i);
      req_data_in[i*DW +: DW] = 64'hD0 + 64'(i);
      req_tag_in[i*TW +: TW] = 8'h10 + 8'(i);
    end
    #2;
    do_reset();
    chk("first_grant_req0", 64'(req_ready_in), 64'b0001);
    // Round-robin with all four requesters reading
    for (int k = 0; k < 5; k++) begin
      chk("rr_ready", 64'(req_ready_in), 64'(4'b0001 << (k % 4)));
      tick();
      chk("rr_mem_valid", 64'(mem_req_valid), 64'd1);
      chk("rr_tag", 64'(mem_req_tag), 64'({8'(8'h10 + 8'(k % 4)), 2'(k % 4)}));
      chk("rr_addr", 64'(mem_req_addr), 64'(32'h100 + 32'(k % 4)));
    end
    // Mid-traffic reset, then pointer must restart at 0
    #1;
    do_reset();
    chk("post_reset_grant_req0", 64'(req_ready_in), 64'b0001);
    req_valid_in = '0;
    #1;
    for (int t = 0; t < 6; t++) begin
      tick();
      mem_rsp_valid = tbl[t].v;
      mem_rsp_tag = tbl[t].tag;
      rsp_ready_out = tbl[t].rdy;
      mem_rsp_data = tbl[t].data;
      #1;
      chk("tbl_rsp_valid", 64'(rsp_valid_out), 64'(tbl[t].e_valid));
      chk("tbl_mem_rsp_ready", 64'(mem_rsp_ready), 64'(tbl[t].e_mrdy));
      chk("tbl_rsp_tag", 64'(rsp_tag_out), 64'(tbl[t].e_tag));
      chk("tbl_rsp_data", rsp_data_out, tbl[t].data);
      mem_rsp_valid = 1'b0;
      rsp_ready_out = 4'hF;
    end
    // Response to an idle requester flags a sticky error
    tick();
    mem_rsp_valid = 1'b1;
    mem_rsp_tag = {8'h3C, 2'd2};
    #1;
    chk("err_rsp_valid", 64'(rsp_valid_out), 64'b0100);
    chk("err_before", 64'(err_out), 64'd0);
    tick();
    mem_rsp_valid = 1'b0;
    chk("err_set", 64'(err_out), 64'd1);
    tick();
    chk("err_sticky", 64'(err_out), 64'd1);
    do_reset();
    // Credit limit of 2 reads on requester 1
    req_valid_in = 4'b0010;
    #1;
    chk("cr_ready0", 64'(req_ready_in), 64'b0010);
    tick();
    chk("cr_ready1", 64'(req_ready_in), 64'b0010);
    chk("cr_tag", 64'(mem_req_tag), 64'({8'h11, 2'd1}));
    tick();
    chk("cr_stall", 64'(req_ready_in), 64'b0000);
    tick();
    chk("cr_stall_hold", 64'(req_ready_in), 64'b0000);
    chk("cr_no_issue", 64'(mem_req_valid), 64'd0);
    mem_rsp_valid = 1'b1;
    mem_rsp_tag = {8'hAA, 2'd1};
    #1;
    chk("cr_rsp_valid", 64'(rsp_valid_out), 64'b0010);
    chk("cr_rsp_tag", 64'(rsp_tag_out), 64'hAA);
    chk("cr_still_stalled", 64'(req_ready_in), 64'b0000);
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    chk("cr_regrant", 64'(req_ready_in), 64'b0010);
    tick();
    chk("cr_regrant_issue", 64'(mem_req_valid), 64'd1);
    chk("cr_full_again", 64'(req_ready_in), 64'b0000);
    // Flush with two reads outstanding on requester 1
    req_valid_in = '0;
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    req_valid_in = 4'hF;
    #1;
    chk("fl_no_grant", 64'(req_ready_in), 64'd0);
    tick();
    chk("fl_no_grant2", 64'(req_ready_in), 64'd0);
    chk("fl_not_done", 64'(flush_done), 64'd0);
    mem_rsp_valid = 1'b1;
    mem_rsp_tag = {8'hB0, 2'd1};
    tick();
    chk("fl_not_done_rsp1", 64'(flush_done), 64'd0);
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    chk("fl_not_done_rsp2", 64'(flush_done), 64'd0);
    chk("fl_no_grant3", 64'(req_ready_in), 64'd0);
    tick();
    chk("fl_done", 64'(flush_done), 64'd1);
    chk("fl_done_no_grant", 64'(req_ready_in), 64'd0);
    tick();
    chk("fl_done_pulse", 64'(flush_done), 64'd0);
    chk("fl_resume", 64'(req_ready_in), 64'b0100);
    chk("fl_no_err", 64'(err_out), 64'd0);
    req_valid_in = '0;
    do_reset();
    // Backpressure: payload must hold while the port stalls
    mem_req_ready = 1'b0;
    req_valid_in = 4'b0001;
    req_rw_in = 4'b0001;
    req_addr_in[0 +: AW] = 32'hA000;
    req_data_in[0 +: DW] = 64'h1234;
    #1;
    chk("bp_first", 64'(req_ready_in), 64'b0001);
    tick();
    req_addr_in[0 +: AW] = 32'hB000;
    req_data_in[0 +: DW] = 64'h5678;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_ready", 64'(req_ready_in), 64'd0);
      chk("bp_addr", 64'(mem_req_addr), 64'hA000);
      chk("bp_valid", 64'(mem_req_valid), 64'd1);
      tick();
    end
    chk("bp_data", mem_req_data, 64'h1234);
    mem_req_ready = 1'b1;
    #1;
    chk("bp_release", 64'(req_ready_in), 64'b0001);
    tick();
    chk("bp_next_addr", 64'(mem_req_addr), 64'hB000);
    chk("bp_next_rw", 64'(mem_req_rw), 64'd1);
    chk("bp_write_no_credit", 64'(req_ready_in), 64'b0001);
    req_valid_in = '0;
    tick();
    chk("bp_idle", 64'(mem_req_valid), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
